// File: rtl/rv_ctrl_pkg.sv
// Shared front-end control types and constants for the fetch PC redirect logic.
package rv_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      TRAP  = 2'd2
   } state_e;

   localparam int unsigned ILEN_BYTES   = 4;
   localparam int unsigned FLUSH_CNT_W  = 3;
   localparam logic [63:0] DEF_RESET_PC = 64'h0;
   localparam logic [63:0] DEF_TRAP_VEC = 64'h100;

endpackage

// File: rtl/pc_redirect_controller_target_calc.sv
// Branch/jump target select and add, plus the word-alignment check on the result.
module pc_target_calc #(
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0] ex_pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_offset,
   input  logic            jump_location,
   input  logic [XLEN-1:0] new_pc_offset,
   output logic [XLEN-1:0] target,
   output logic            misaligned
);

   // Branch wins when both flags are set; JALR clears bit 0 before the check.
   always_comb begin
      target = ex_pc + new_pc_offset;
      if (branch_taken)
         target = ex_pc + branch_offset;
      else if (jump_location)
         target = {new_pc_offset[XLEN-1:1], 1'b0};
      misaligned = |target[1:0];
   end

endmodule

// File: rtl/pc_redirect_controller.sv
// Fetch PC owner: advance/hold/redirect, fixed-length flush window and misaligned-target trap.
module pc_redirect_controller
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEF_RESET_PC),
   parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'(DEF_TRAP_VEC),
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_offset,
   input  logic            jump_taken,
   input  logic            jump_location,
   input  logic [XLEN-1:0] new_pc_offset,
   output logic [XLEN-1:0] pc,
   output logic            fetch_valid,
   output logic            flush,
   output logic [XLEN-1:0] link_data,
   output logic            trap,
   output logic [31:0]     redirect_count
);

   state_e                 state_q, state_d;
   logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]        pc_d;
   logic [31:0]            count_d;
   logic [XLEN-1:0]        target;
   logic                   misaligned;
   logic                   redirect_req;

   pc_target_calc #(.XLEN(XLEN)) u_target (
      .ex_pc         (ex_pc),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump_location (jump_location),
      .new_pc_offset (new_pc_offset),
      .target        (target),
      .misaligned    (misaligned)
   );

   assign redirect_req = ex_valid & (branch_taken | jump_taken);
   assign link_data    = ex_pc + XLEN'(ILEN_BYTES);
   assign fetch_valid  = (state_q == RUN) & ~rst;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc;
      count_d = redirect_count;
      flush   = 1'b0;
      trap    = 1'b0;
      unique case (state_q)
         RUN: begin
            if (redirect_req) begin
               flush = 1'b1;
               if (misaligned) begin
                  trap    = 1'b1;
                  pc_d    = TRAP_VEC;
                  state_d = TRAP;
               end else begin
                  pc_d    = target;
                  count_d = redirect_count + 32'd1;
                  cnt_d   = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                  state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
               end
            end else if (!stall) begin
               pc_d = pc + XLEN'(ILEN_BYTES);
            end
         end
         // The request cycle already counted as one flush cycle, so leave on the last count.
         FLUSH: begin
            flush = 1'b1;
            cnt_d = cnt_q - FLUSH_CNT_W'(1);
            if (cnt_q <= FLUSH_CNT_W'(1))
               state_d = RUN;
         end
         TRAP: begin
            flush   = 1'b1;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
      if (rst) begin
         flush = 1'b0;
         trap  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RUN;
         cnt_q          <= '0;
         pc             <= RESET_PC;
         redirect_count <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pc             <= pc_d;
         redirect_count <= count_d;
      end
   end

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed, table-driven bench for pc_redirect_controller; one table row per clock cycle.
module tb_pc_redirect_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        ex_valid;
   logic [63:0] ex_pc;
   logic        branch_taken;
   logic [63:0] branch_offset;
   logic        jump_taken;
   logic        jump_location;
   logic [63:0] new_pc_offset;
   logic [63:0] pc;
   logic        fetch_valid;
   logic        flush;
   logic [63:0] link_data;
   logic        trap;
   logic [31:0] redirect_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pc_redirect_controller #(
      .XLEN         (64),
      .RESET_PC     (64'h0),
      .TRAP_VEC     (64'h100),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .branch_taken   (branch_taken),
      .branch_offset  (branch_offset),
      .jump_taken     (jump_taken),
      .jump_location  (jump_location),
      .new_pc_offset  (new_pc_offset),
      .pc             (pc),
      .fetch_valid    (fetch_valid),
      .flush          (flush),
      .link_data      (link_data),
      .trap           (trap),
      .redirect_count (redirect_count)
   );

   typedef struct {
      logic        rst, stall, exv;
      logic [63:0] epc;
      logic        br;
      logic [63:0] boff;
      logic        jmp, jloc;
      logic [63:0] npo;
      logic [63:0] e_pc;
      logic        e_fv, e_fl, e_tr;
      logic [31:0] e_rc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic r, input logic st, input logic ev,
                              input logic [63:0] epc, input logic b, input logic [63:0] bo,
                              input logic j, input logic jl, input logic [63:0] npo,
                              input logic [63:0] e_pc, input logic fv, input logic fl,
                              input logic tr, input logic [31:0] rc);
      vec_t t;
      t.rst = r; t.stall = st; t.exv = ev; t.epc = epc; t.br = b; t.boff = bo;
      t.jmp = j; t.jloc = jl; t.npo = npo;
      t.e_pc = e_pc; t.e_fv = fv; t.e_fl = fl; t.e_tr = tr; t.e_rc = rc;
      return t;
   endfunction

   task automatic chk(input string name, input int row, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
   endtask

   task automatic idle_inputs();
      rst = 1'b0; stall = 1'b0; ex_valid = 1'b0; ex_pc = '0; branch_taken = 1'b0;
      branch_offset = '0; jump_taken = 1'b0; jump_location = 1'b0; new_pc_offset = '0;
   endtask

   initial begin
      //           rst st ev ex_pc                  br off                    j  jl npo                    | pc                     fv fl tr rc
      tbl.push_back(v(1, 0, 1, 64'h8,                1, 64'h10,                0, 0, 64'h0,                 64'h0,                 0, 0, 0, 0)); // 0 reset gates flush
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h0,                 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h4,                 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h8,                 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'hC,                 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 64'h8,                1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 64'h0,               64'h10,                1, 1, 0, 0)); // 5 branch -8
      tbl.push_back(v(0, 1, 1, 64'h0,                0, 64'h0,                 1, 1, 64'h300,               64'h0,                 0, 1, 0, 1)); // 6 FLUSH ignores req/stall
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h0,                 1, 0, 0, 1));
      tbl.push_back(v(0, 0, 1, 64'h20,               0, 64'h0,                 1, 1, 64'h201,               64'h4,                 1, 1, 0, 1)); // 8 JALR
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h200,               0, 1, 0, 2));
      tbl.push_back(v(0, 0, 1, 64'h40,               0, 64'h0,                 1, 0, 64'h6,                 64'h200,               1, 1, 1, 2)); // 10 JAL misaligned
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h100,               0, 1, 0, 2)); // 11 TRAP
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h100,               1, 0, 0, 2));
      tbl.push_back(v(0, 1, 1, 64'h70,               1, 64'h10,                0, 0, 64'h0,                 64'h104,               1, 1, 0, 2)); // 13 redirect beats stall
      tbl.push_back(v(0, 1, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h80,                0, 1, 0, 3));
      tbl.push_back(v(0, 1, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h80,                1, 0, 0, 3)); // 15 stall holds
      tbl.push_back(v(0, 1, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h80,                1, 0, 0, 3));
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h80,                1, 0, 0, 3));
      tbl.push_back(v(0, 0, 1, 64'h100,              1, 64'h20,                1, 1, 64'h400,               64'h84,                1, 1, 0, 3)); // 18 branch wins over jump
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h120,               0, 1, 0, 4));
      tbl.push_back(v(0, 0, 0, 64'h50,               1, 64'h40,                1, 0, 64'h8,                 64'h120,               1, 0, 0, 4)); // 20 no ex_valid
      tbl.push_back(v(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 1, 64'h20,             0, 0, 64'h0,                 64'h124,               1, 1, 0, 4)); // 21 target wraps
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h10,                0, 1, 0, 5));
      tbl.push_back(v(0, 0, 1, 64'h30,               1, 64'h10,                0, 0, 64'h0,                 64'h10,                1, 1, 0, 5));
      tbl.push_back(v(1, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h40,                0, 0, 0, 6)); // 24 reset mid-FLUSH
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h0,                 1, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 64'h0,                0, 64'h0,                 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h4,               1, 1, 0, 0)); // 26 JALR to top
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 1));
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 1));
      tbl.push_back(v(0, 0, 1, 64'h0,                0, 64'h0,                 1, 0, 64'h2,                 64'h0,                 1, 1, 1, 1)); // 29 pc wrapped; JAL misaligned
      tbl.push_back(v(1, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h100,               0, 0, 0, 1)); // 30 reset in TRAP
      tbl.push_back(v(0, 0, 0, 64'h0,                0, 64'h0,                 0, 0, 64'h0,                 64'h0,                 1, 0, 0, 0));

      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst = tbl[i].rst; stall = tbl[i].stall; ex_valid = tbl[i].exv; ex_pc = tbl[i].epc;
         branch_taken = tbl[i].br; branch_offset = tbl[i].boff; jump_taken = tbl[i].jmp;
         jump_location = tbl[i].jloc; new_pc_offset = tbl[i].npo;
         #1;
         chk("pc",             i, pc,                     tbl[i].e_pc);
         chk("fetch_valid",    i, 64'(fetch_valid),       64'(tbl[i].e_fv));
         chk("flush",          i, 64'(flush),             64'(tbl[i].e_fl));
         chk("trap",           i, 64'(trap),              64'(tbl[i].e_tr));
         chk("redirect_count", i, 64'(redirect_count),    64'(tbl[i].e_rc));
         chk("link_data",      i, link_data,              tbl[i].epc + 64'd4);
      end

      // redirect_count wrap: preload the counter at its maximum, then take one redirect.
      @(negedge clk);
      idle_inputs();
      force dut.redirect_count = 32'hFFFF_FFFF;
      #1;
      release dut.redirect_count;
      #1;
      chk("rc_preload", 100, 64'(redirect_count), 64'hFFFF_FFFF);
      ex_valid = 1'b1; branch_taken = 1'b1; ex_pc = 64'h0; branch_offset = 64'h40;
      #1;
      chk("wrap_flush", 100, 64'(flush), 64'h1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("rc_wrap",     101, 64'(redirect_count), 64'h0);
      chk("wrap_pc",     101, pc,                  64'h40);
      chk("wrap_fvalid", 101, 64'(fetch_valid),    64'h0);
      @(negedge clk);
      #1;
      chk("wrap_run_pc", 102, pc,                  64'h40);
      chk("wrap_run_fv", 102, 64'(fetch_valid),    64'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
